// File: rtl/uart_frame_decoder.sv
// Frame receiver behind the UART: hunts for SOF, parses length/payload/checksum,
// streams payload bytes to the client and answers each frame with ACK or NAK.
module uart_frame_decoder #(
  parameter logic [7:0]  SofByte       = 8'hA5,
  parameter int unsigned MaxLen        = 16,
  parameter int unsigned TimeoutCycles = 500_000,
  parameter logic [7:0]  AckByte       = 8'h06,
  parameter logic [7:0]  NakByte       = 8'h15,
  localparam int unsigned IdxW         = (MaxLen > 1) ? $clog2(MaxLen) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_rx_rdy,
  output logic            o_rx_req,
  input  logic [7:0]      i_rx_data,
  input  logic            i_tx_rdy,
  output logic            o_tx_req,
  output logic [7:0]      o_tx_data,
  output logic            o_byte_valid,
  output logic [7:0]      o_byte_data,
  output logic [IdxW-1:0] o_byte_idx,
  output logic            o_frame_ok,
  output logic            o_frame_err,
  output logic [1:0]      o_err_code,
  output logic [15:0]     o_frame_cnt,
  output logic [15:0]     o_err_cnt
);

  localparam int unsigned TmoW    = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);
  localparam logic [7:0]  MaxLenB = 8'(MaxLen);

  typedef enum logic [2:0] {StIdle, StLen, StPayload, StCsum, StResp} state_e;

  state_e          r_state;
  logic            r_pend;
  logic [7:0]      r_len;
  logic [7:0]      r_sum;
  logic [7:0]      r_cnt;
  logic [TmoW-1:0] r_tmo;
  logic            r_tx_req;
  logic [7:0]      r_tx_data;
  logic            r_byte_valid;
  logic [7:0]      r_byte_data;
  logic [IdxW-1:0] r_byte_idx;
  logic            r_frame_ok;
  logic            r_frame_err;
  logic [1:0]      r_err_code;
  logic [15:0]     r_frame_cnt;
  logic [15:0]     r_err_cnt;

  logic            w_active;
  logic            w_tmo_hit;
  logic [7:0]      w_sum_next;
  logic            w_good;
  logic            w_fail;
  logic [1:0]      w_code;

  // r_pend marks the cycle in which the popped byte is on i_rx_data
  assign o_rx_req   = i_rst_n && (r_state != StResp) && !r_pend && i_rx_rdy;
  assign w_active   = (r_state == StLen) || (r_state == StPayload) || (r_state == StCsum);
  assign w_tmo_hit  = w_active && !r_pend && (r_tmo == TmoLast);
  assign w_sum_next = r_sum + i_rx_data;

  always_comb begin
    w_good = 1'b0;
    w_fail = 1'b0;
    w_code = 2'd0;
    unique case (r_state)
      StLen: begin
        if (r_pend && (i_rx_data > MaxLenB)) begin
          w_fail = 1'b1;
          w_code = 2'd2;
        end else if (w_tmo_hit) begin
          w_fail = 1'b1;
          w_code = 2'd3;
        end
      end
      StPayload: begin
        if (w_tmo_hit) begin
          w_fail = 1'b1;
          w_code = 2'd3;
        end
      end
      StCsum: begin
        if (r_pend) begin
          w_good = (w_sum_next == 8'd0);
          w_fail = (w_sum_next != 8'd0);
          w_code = (w_sum_next == 8'd0) ? 2'd0 : 2'd1;
        end else if (w_tmo_hit) begin
          w_fail = 1'b1;
          w_code = 2'd3;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_pend       <= 1'b0;
      r_len        <= '0;
      r_sum        <= '0;
      r_cnt        <= '0;
      r_tmo        <= '0;
      r_tx_req     <= 1'b0;
      r_tx_data    <= '0;
      r_byte_valid <= 1'b0;
      r_byte_data  <= '0;
      r_byte_idx   <= '0;
      r_frame_ok   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_code   <= '0;
      r_frame_cnt  <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_pend       <= o_rx_req;
      r_tx_req     <= 1'b0;
      r_byte_valid <= 1'b0;
      r_frame_ok   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_tmo        <= (w_active && !r_pend) ? r_tmo + 1'b1 : '0;
      unique case (r_state)
        StIdle: begin
          if (r_pend && (i_rx_data == SofByte)) begin
            r_sum   <= '0;
            r_cnt   <= '0;
            r_state <= StLen;
          end
        end
        StLen: begin
          if (r_pend) begin
            r_len   <= i_rx_data;
            r_sum   <= i_rx_data;
            r_state <= (i_rx_data == 8'd0) ? StCsum : StPayload;
          end
        end
        StPayload: begin
          if (r_pend) begin
            r_byte_valid <= 1'b1;
            r_byte_data  <= i_rx_data;
            r_byte_idx   <= r_cnt[IdxW-1:0];
            r_sum        <= w_sum_next;
            r_cnt        <= r_cnt + 8'd1;
            if (r_cnt == r_len - 8'd1) r_state <= StCsum;
          end
        end
        StCsum: ;
        StResp: begin
          if (i_tx_rdy) begin
            r_tx_req  <= 1'b1;
            r_tx_data <= (r_err_code == 2'd0) ? AckByte : NakByte;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
      // Frame end overrides any state update made above
      if (w_good || w_fail) begin
        r_state     <= StResp;
        r_frame_ok  <= w_good;
        r_frame_err <= w_fail;
        r_err_code  <= w_code;
        if (w_good) r_frame_cnt <= r_frame_cnt + 16'd1;
        else        r_err_cnt   <= r_err_cnt + 16'd1;
      end
    end
  end

  assign o_tx_req     = r_tx_req;
  assign o_tx_data    = r_tx_data;
  assign o_byte_valid = r_byte_valid;
  assign o_byte_data  = r_byte_data;
  assign o_byte_idx   = r_byte_idx;
  assign o_frame_ok   = r_frame_ok;
  assign o_frame_err  = r_frame_err;
  assign o_err_code   = r_err_code;
  assign o_frame_cnt  = r_frame_cnt;
  assign o_err_cnt    = r_err_cnt;

endmodule
